// File: rtl/pe_cluster_collector.sv
// Collects one-cycle row result pulses into per-row holds and drains them
// through one valid/ready port, either per row (pass) or summed per row group (reduce).
module pe_cluster_collector #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_ROWS   = 16,
    parameter int OUT_WIDTH  = 20,
    localparam int LOG_NROWS = $clog2(NUM_ROWS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_cfg_load,
    input  logic                           i_mode,
    input  logic [LOG_NROWS:0]             i_group_size,
    input  logic [NUM_ROWS-1:0]            i_row_en,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] i_row_data,
    input  logic [NUM_ROWS-1:0]            i_row_valid,
    input  logic                           i_ready,
    input  logic                           i_clear_ovf,
    output logic [OUT_WIDTH-1:0]           o_data,
    output logic [LOG_NROWS-1:0]           o_row_id,
    output logic                           o_valid,
    output logic                           o_overflow,
    output logic                           o_cfg_err,
    output logic                           o_idle
);

    // Sum width covers a full-height group without wrap before saturation.
    localparam int SUM_W = (OUT_WIDTH > DATA_WIDTH + LOG_NROWS) ? OUT_WIDTH + 1
                                                                : DATA_WIDTH + LOG_NROWS + 1;
    localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {PASS = 1'b0, REDUCE = 1'b1} mode_t;

    mode_t                                mode;
    logic [LOG_NROWS:0]                   group_size;
    logic [NUM_ROWS-1:0]                  row_en;
    logic [NUM_ROWS-1:0]                  hold_vld;
    logic [NUM_ROWS-1:0][DATA_WIDTH-1:0]  hold_data;
    logic [LOG_NROWS-1:0]                 rr_ptr;

    logic [NUM_ROWS-1:0][NUM_ROWS-1:0]    grp_mask;
    logic [NUM_ROWS-1:0]                  cand;
    logic                                 found;
    logic [LOG_NROWS-1:0]                 grant;
    logic                                 load;
    logic                                 drain;
    logic [NUM_ROWS-1:0]                  clr;
    logic [NUM_ROWS-1:0]                  capture;
    logic [NUM_ROWS-1:0]                  drop;
    logic signed [SUM_W-1:0]              sum;
    logic                                 sat;
    logic [OUT_WIDTH-1:0]                 next_data;
    logic [LOG_NROWS:0]                   gs_eff;

    assign o_idle = !(|hold_vld) && !o_valid;
    assign load   = !o_valid || i_ready;
    assign drain  = load && found;

    always_comb begin
        gs_eff = i_group_size;
        if (i_group_size == '0)
            gs_eff = (LOG_NROWS+1)'(1);
        else if (i_group_size > (LOG_NROWS+1)'(NUM_ROWS))
            gs_eff = (LOG_NROWS+1)'(NUM_ROWS);
    end

    // A candidate is a full hold (pass) or a group whose enabled rows are all full (reduce).
    always_comb begin
        grp_mask = '0;
        cand     = '0;
        for (int k = 0; k < NUM_ROWS; k++) begin
            for (int r = 0; r < NUM_ROWS; r++)
                grp_mask[k][r] = (r >= k * int'(group_size)) && (r < (k + 1) * int'(group_size));
            if (mode == REDUCE)
                cand[k] = (|(grp_mask[k] & row_en)) && ((grp_mask[k] & row_en & ~hold_vld) == '0);
            else
                cand[k] = hold_vld[k];
        end
    end

    always_comb begin
        int idx;
        logic [LOG_NROWS-1:0] sel;
        idx   = 0;
        sel   = '0;
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_ROWS)
                idx = idx - NUM_ROWS;
            sel = LOG_NROWS'(idx);
            if (!found && cand[sel]) begin
                found = 1'b1;
                grant = sel;
            end
        end
    end

    always_comb begin
        clr = '0;
        if (drain)
            clr = (mode == REDUCE) ? (grp_mask[grant] & row_en) : (NUM_ROWS'(1) << grant);
    end

    always_comb begin
        sum = '0;
        for (int r = 0; r < NUM_ROWS; r++)
            if (grp_mask[grant][r] && row_en[r])
                sum = sum + SUM_W'($signed(hold_data[r]));
        sat = (sum > SAT_MAX) || (sum < SAT_MIN);
        if (mode == REDUCE) begin
            if (sum > SAT_MAX)
                next_data = SAT_MAX[OUT_WIDTH-1:0];
            else if (sum < SAT_MIN)
                next_data = SAT_MIN[OUT_WIDTH-1:0];
            else
                next_data = sum[OUT_WIDTH-1:0];
        end else begin
            next_data = OUT_WIDTH'($signed(hold_data[grant]));
        end
    end

    // A hold being drained this cycle can accept a new pulse on the same edge.
    assign capture = i_row_valid & row_en & (~hold_vld | clr);
    assign drop    = i_row_valid & row_en & hold_vld & ~clr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode       <= PASS;
            group_size <= (LOG_NROWS+1)'(1);
            row_en     <= '1;
            hold_vld   <= '0;
            hold_data  <= '0;
            rr_ptr     <= '0;
            o_data     <= '0;
            o_row_id   <= '0;
            o_valid    <= 1'b0;
            o_overflow <= 1'b0;
            o_cfg_err  <= 1'b0;
        end else begin
            o_cfg_err <= i_cfg_load && !o_idle;
            if (i_cfg_load && o_idle) begin
                mode       <= mode_t'(i_mode);
                group_size <= gs_eff;
                row_en     <= i_row_en;
            end

            hold_vld <= (hold_vld & ~clr) | capture;
            for (int r = 0; r < NUM_ROWS; r++)
                if (capture[r])
                    hold_data[r] <= i_row_data[r*DATA_WIDTH +: DATA_WIDTH];

            if (load) begin
                o_valid <= found;
                if (found) begin
                    o_data   <= next_data;
                    o_row_id <= grant;
                    rr_ptr   <= (grant == LOG_NROWS'(NUM_ROWS-1)) ? '0 : grant + 1'b1;
                end
            end

            // A new overflow event beats a simultaneous clear.
            if ((|drop) || (drain && mode == REDUCE && sat))
                o_overflow <= 1'b1;
            else if (i_clear_ovf)
                o_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pe_cluster_collector.sv
// Directed bench for pe_cluster_collector: table-driven pass/reduce vectors plus
// hand sequences for saturation, config error, partial groups and async reset.
module tb_pe_cluster_collector;

    localparam int DW = 16;
    localparam int NR = 16;
    localparam int OW = 20;
    localparam int LN = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic            cfg_load = 1'b0;
    logic            mode = 1'b0;
    logic [LN:0]     gsize = '0;
    logic [NR-1:0]   row_en = '1;
    logic [NR-1:0]   row_valid = '0;
    logic [NR*DW-1:0] row_data = '0;
    logic            ready = 1'b0;
    logic            clear_ovf = 1'b0;

    logic [OW-1:0]   o_data;
    logic [LN-1:0]   o_row_id;
    logic            o_valid, o_overflow, o_cfg_err, o_idle;
    logic [16:0]     s_data;
    logic [LN-1:0]   s_row_id;
    logic            s_valid, s_overflow, s_cfg_err, s_idle;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pe_cluster_collector #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .OUT_WIDTH(OW)) dut (
        .clk(clk), .reset(reset), .i_cfg_load(cfg_load), .i_mode(mode),
        .i_group_size(gsize), .i_row_en(row_en), .i_row_data(row_data),
        .i_row_valid(row_valid), .i_ready(ready), .i_clear_ovf(clear_ovf),
        .o_data(o_data), .o_row_id(o_row_id), .o_valid(o_valid),
        .o_overflow(o_overflow), .o_cfg_err(o_cfg_err), .o_idle(o_idle)
    );

    // Narrow-output copy used for the saturation case.
    pe_cluster_collector #(.DATA_WIDTH(DW), .NUM_ROWS(NR), .OUT_WIDTH(17)) dut17 (
        .clk(clk), .reset(reset), .i_cfg_load(cfg_load), .i_mode(mode),
        .i_group_size(gsize), .i_row_en(row_en), .i_row_data(row_data),
        .i_row_valid(row_valid), .i_ready(ready), .i_clear_ovf(clear_ovf),
        .o_data(s_data), .o_row_id(s_row_id), .o_valid(s_valid),
        .o_overflow(s_overflow), .o_cfg_err(s_cfg_err), .o_idle(s_idle)
    );

    typedef struct {
        string          nm;
        logic           cfg;
        logic           md;
        logic [LN:0]    gs;
        logic [NR-1:0]  en;
        logic [NR-1:0]  rv;
        logic [NR*DW-1:0] rd;
        logic           rdy;
        logic           clr;
        logic           ev;
        logic [OW-1:0]  ed;
        logic [LN-1:0]  eid;
        logic           eovf;
    } vec_t;

    vec_t tab[$];

    function automatic logic [NR*DW-1:0] rd(input int r, input int v);
        logic [NR*DW-1:0] x;
        x = '0;
        x[r*DW +: DW] = DW'(v);
        return x;
    endfunction

    task automatic add(input string nm, input logic [NR-1:0] rv, input logic [NR*DW-1:0] d,
                       input logic rdy, input logic clr, input logic ev, input logic [OW-1:0] ed,
                       input logic [LN-1:0] eid, input logic eovf);
        vec_t t;
        t.nm = nm; t.cfg = 1'b0; t.md = 1'b0; t.gs = '0; t.en = '0;
        t.rv = rv; t.rd = d; t.rdy = rdy; t.clr = clr;
        t.ev = ev; t.ed = ed; t.eid = eid; t.eovf = eovf;
        tab.push_back(t);
    endtask

    task automatic add_cfg(input string nm, input logic md, input logic [LN:0] gs, input logic [NR-1:0] en);
        vec_t t;
        t.nm = nm; t.cfg = 1'b1; t.md = md; t.gs = gs; t.en = en;
        t.rv = '0; t.rd = '0; t.rdy = 1'b1; t.clr = 1'b0;
        t.ev = 1'b0; t.ed = '0; t.eid = '0; t.eovf = 1'b0;
        tab.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic ev, input logic [OW-1:0] ed, input logic [LN-1:0] eid);
        chk({nm, "_valid"}, 32'(o_valid), 32'(ev));
        if (ev) begin
            chk({nm, "_data"}, 32'(o_data), 32'(ed));
            chk({nm, "_id"}, 32'(o_row_id), 32'(eid));
        end
    endtask

    task automatic cfg(input logic md, input logic [LN:0] gs, input logic [NR-1:0] en);
        cfg_load = 1'b1; mode = md; gsize = gs; row_en = en;
        step();
        cfg_load = 1'b0;
    endtask

    task automatic pulse(input logic [NR-1:0] rv, input logic [NR*DW-1:0] d);
        row_valid = rv; row_data = d;
        step();
        row_valid = '0; row_data = '0;
    endtask

    initial begin
        // Pass mode, three rows at once, drained in round-robin order.
        add("p_cap",  16'h0089, rd(0, 5) | rd(3, -2) | rd(7, 9), 1'b1, 1'b0, 1'b0, 20'd0, 4'd0, 1'b0);
        add("p_r0",   16'h0000, '0, 1'b1, 1'b0, 1'b1, 20'd5,      4'd0, 1'b0);
        add("p_r3",   16'h0000, '0, 1'b1, 1'b0, 1'b1, 20'hFFFFE,  4'd3, 1'b0);
        add("p_r7",   16'h0000, '0, 1'b1, 1'b0, 1'b1, 20'd9,      4'd7, 1'b0);
        add("p_done", 16'h0000, '0, 1'b1, 1'b0, 1'b0, 20'd0,      4'd0, 1'b0);
        // Backpressure on row 2: third pulse is dropped.
        add("h_11",    16'h0004, rd(2, 11), 1'b0, 1'b0, 1'b0, 20'd0,  4'd0, 1'b0);
        add("h_out11", 16'h0000, '0,        1'b0, 1'b0, 1'b1, 20'd11, 4'd2, 1'b0);
        add("h_12",    16'h0004, rd(2, 12), 1'b0, 1'b0, 1'b1, 20'd11, 4'd2, 1'b0);
        add("h_13",    16'h0004, rd(2, 13), 1'b0, 1'b0, 1'b1, 20'd11, 4'd2, 1'b1);
        add("h_hold",  16'h0000, '0,        1'b0, 1'b0, 1'b1, 20'd11, 4'd2, 1'b1);
        add("h_out12", 16'h0000, '0,        1'b1, 1'b0, 1'b1, 20'd12, 4'd2, 1'b1);
        add("h_empty", 16'h0000, '0,        1'b1, 1'b0, 1'b0, 20'd0,  4'd0, 1'b1);
        add("h_clr",   16'h0000, '0,        1'b1, 1'b1, 1'b0, 20'd0,  4'd0, 1'b0);
        // Reduce G=4 over rows 0..3, members arriving on separate cycles; row 4 disabled.
        add_cfg("r_cfg", 1'b1, 5'd4, 16'h000F);
        add("r_m0",   16'h0001, rd(0, 1000),               1'b1, 1'b0, 1'b0, 20'd0,    4'd0, 1'b0);
        add("r_m1",   16'h0012, rd(1, 2000) | rd(4, 55),   1'b1, 1'b0, 1'b0, 20'd0,    4'd0, 1'b0);
        add("r_m2",   16'h0004, rd(2, -500),               1'b1, 1'b0, 1'b0, 20'd0,    4'd0, 1'b0);
        add("r_m3",   16'h0008, rd(3, 7),                  1'b1, 1'b0, 1'b0, 20'd0,    4'd0, 1'b0);
        add("r_sum",  16'h0000, '0,                        1'b1, 1'b0, 1'b1, 20'd2507, 4'd0, 1'b0);
        add("r_done", 16'h0000, '0,                        1'b1, 1'b0, 1'b0, 20'd0,    4'd0, 1'b0);

        #12;
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_data", 32'(o_data), 32'd0);
        chk("rst_id", 32'(o_row_id), 32'd0);
        chk("rst_ovf", 32'(o_overflow), 32'd0);
        chk("rst_err", 32'(o_cfg_err), 32'd0);
        chk("rst_idle", 32'(o_idle), 32'd1);
        reset = 1'b1;
        step();

        foreach (tab[i]) begin
            cfg_load = tab[i].cfg; mode = tab[i].md; gsize = tab[i].gs; row_en = tab[i].en;
            row_valid = tab[i].rv; row_data = tab[i].rd; ready = tab[i].rdy; clear_ovf = tab[i].clr;
            step();
            chk_out(tab[i].nm, tab[i].ev, tab[i].ed, tab[i].eid);
            chk({tab[i].nm, "_ovf"}, 32'(o_overflow), 32'(tab[i].eovf));
        end
        cfg_load = 1'b0; row_valid = '0; row_data = '0; clear_ovf = 1'b0; ready = 1'b1;
        chk("r_idle", 32'(o_idle), 32'd1);

        // Saturation on the 17-bit copy; the 20-bit copy holds the exact sum.
        pulse(16'h000F, rd(0, 32767) | rd(1, 32767) | rd(2, 32767) | rd(3, 32767));
        step();
        chk("sat17_valid", 32'(s_valid), 32'd1);
        chk("sat17_data", 32'(s_data), 32'h0FFFF);
        chk("sat17_ovf", 32'(s_overflow), 32'd1);
        chk_out("sat20", 1'b1, 20'h1FFFC, 4'd0);
        chk("sat20_ovf", 32'(o_overflow), 32'd0);
        clear_ovf = 1'b1;
        step();
        clear_ovf = 1'b0;
        chk("sat17_clr", 32'(s_overflow), 32'd0);
        pulse(16'h000F, rd(0, 32767) | rd(1, 32767) | rd(2, 32767) | rd(3, 32767));
        clear_ovf = 1'b1;
        step();
        chk("sat17_setwins", 32'(s_overflow), 32'd1);
        step();
        clear_ovf = 1'b0;
        chk("sat17_clr2", 32'(s_overflow), 32'd0);

        // Config load while busy is rejected; accepted once idle.
        ready = 1'b0;
        pulse(16'h000F, rd(0, 1) | rd(1, 2) | rd(2, 3) | rd(3, 4));
        step();
        chk_out("ce_busy", 1'b1, 20'd10, 4'd0);
        cfg(1'b0, 5'd1, 16'hFFFF);
        chk("ce_err", 32'(o_cfg_err), 32'd1);
        step();
        chk("ce_err_pulse", 32'(o_cfg_err), 32'd0);
        ready = 1'b1;
        step();
        chk("ce_idle", 32'(o_idle), 32'd1);
        pulse(16'h000F, rd(0, 1) | rd(1, 1) | rd(2, 1) | rd(3, 1));
        step();
        chk_out("ce_still_reduce", 1'b1, 20'd4, 4'd0);
        step();
        cfg(1'b0, 5'd1, 16'hFFFF);
        chk("ce_ok_err", 32'(o_cfg_err), 32'd0);
        pulse(16'h0020, rd(5, 77));
        step();
        chk_out("ce_pass", 1'b1, 20'd77, 4'd5);
        step();

        // Group size 0 acts as 1; oversize clamps to all rows.
        cfg(1'b1, 5'd0, 16'hFFFF);
        pulse(16'h0040, rd(6, -3));
        step();
        chk_out("g0", 1'b1, 20'hFFFFD, 4'd6);
        step();
        cfg(1'b1, 5'd20, 16'h0011);
        pulse(16'h0011, rd(0, 10) | rd(4, 20));
        step();
        chk_out("gclamp", 1'b1, 20'd30, 4'd0);
        step();

        // Partial last group: G=3, only row 15 enabled -> group 5.
        cfg(1'b1, 5'd3, 16'h8000);
        pulse(16'hC000, rd(15, 4) | rd(14, 9));
        step();
        chk_out("g3_part", 1'b1, 20'd4, 4'd5);
        step();
        chk_out("g3_done", 1'b0, 20'd0, 4'd0);

        // Async reset mid-transfer discards output and holds.
        ready = 1'b0;
        pulse(16'h8000, rd(15, 6));
        step();
        chk_out("mr_busy", 1'b1, 20'd6, 4'd5);
        pulse(16'h8000, rd(15, 8));
        #2;
        reset = 1'b0;
        #1;
        chk("mr_valid", 32'(o_valid), 32'd0);
        chk("mr_idle", 32'(o_idle), 32'd1);
        chk("mr_data", 32'(o_data), 32'd0);
        #2;
        reset = 1'b1;
        ready = 1'b1;
        step();
        pulse(16'h0010, rd(4, 3));
        step();
        chk_out("mr_pass_cfg", 1'b1, 20'd3, 4'd4);
        step();
        chk("mr_end_idle", 32'(o_idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pe_cluster_collector.md
Name: pe_cluster_collector

Overview:
- Output stage behind the PE row array. Replaces the wired-OR merge of row partial sums, which corrupts data when two rows pulse valid in the same cycle.
- Captures per-row output pulses in holding registers and drains them through a single valid/ready port.
- Two modes: pass mode forwards each row's result tagged with its row index; reduce mode adds vertical groups of rows, for row-stationary filter reduction, and emits one saturated sum per group.

Parameters:
- DATA_WIDTH, 16, signed width of each row output.
- NUM_ROWS, 16, number of PE rows feeding the collector.
- OUT_WIDTH, 20, signed width of the output. Must be >= DATA_WIDTH.
- LOG_NROWS, $clog2(NUM_ROWS), localparam.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- i_cfg_load  in  1  pulse; latches i_mode, i_group_size and i_row_en.
- i_mode  in  1  0 = pass, 1 = reduce.
- i_group_size  in  LOG_NROWS+1  rows per reduction group.
- i_row_en  in  NUM_ROWS  row enable mask.
- i_row_data  in  NUM_ROWS*DATA_WIDTH  row outputs; row r occupies bits [r*DATA_WIDTH +: DATA_WIDTH].
- i_row_valid  in  NUM_ROWS  one-cycle valid pulses, one per row.
- i_ready  in  1  downstream ready.
- i_clear_ovf  in  1  clears o_overflow.
- o_data  out  OUT_WIDTH  output value.
- o_row_id  out  LOG_NROWS  row index (pass mode) or group index (reduce mode).
- o_valid  out  1  output valid.
- o_overflow  out  1  sticky flag: data dropped or sum saturated.
- o_cfg_err  out  1  pulse: i_cfg_load arrived while not idle.
- o_idle  out  1  all holding registers empty and o_valid low.

Behaviour:
- Reset values:
  - Holding registers empty; round-robin pointer 0.
  - Latched config: mode = pass, group size = 1, row_en = all ones.
  - o_data = 0, o_row_id = 0, o_valid = 0, o_overflow = 0, o_cfg_err = 0, o_idle = 1.
- Config:
  - i_cfg_load with o_idle = 1: config registers update on the next edge.
  - i_cfg_load with o_idle = 0: config unchanged; o_cfg_err high for exactly one cycle.
  - Group size 0 is treated as 1. Group size > NUM_ROWS is clamped to NUM_ROWS.
- Capture:
  - i_row_valid[r] is ignored when latched row_en[r] = 0.
  - When the hold for row r is empty, or is being drained in the same cycle, the data is captured at the next edge.
  - When the hold is full and not draining, the new data is dropped, the held value is kept, and o_overflow is set.
- Output register:
  - Loads when o_valid = 0, or when o_valid && i_ready.
  - Otherwise o_data, o_row_id and o_valid hold stable. No change while valid is high and ready is low.
- Pass mode:
  - Round-robin grant over full holds. The search starts at (last grant + 1) mod NUM_ROWS.
  - The granted hold is cleared.
  - o_data is the held value sign-extended to OUT_WIDTH; o_row_id is the row index.
- Reduce mode:
  - Group k covers rows k*G .. min(k*G+G-1, NUM_ROWS-1). The last group may be partial.
  - A group is ready when it has at least one enabled row and every enabled row in it holds data.
  - Round-robin over ready groups.
  - o_data is the signed sum of the enabled members, saturated to the OUT_WIDTH signed range; saturation sets o_overflow.
  - All member holds of the granted group are cleared together.
  - A group with no enabled rows never issues.
- Latency:
  - Row pulse at edge t: captured at t+1; o_valid earliest at t+2 when the output is free.
  - Sustained throughput: one result per cycle while i_ready = 1.
- Simultaneous events:
  - Drain and capture on the same row in one cycle: both succeed.
  - i_clear_ovf coinciding with a new overflow event: the set wins.
- Reset mid-operation: all held and in-flight data are discarded with no output; the block returns to its reset state immediately (asynchronous).

Test Plan:
- Pass mode, row_en = all ones, i_ready = 1; rows 0, 3, 7 pulse together with 5, -2, 9 -> three outputs on consecutive cycles, earliest at t+2: (0, 5), (3, -2 sign-extended to 0xFFFFE), (7, 9); o_overflow stays 0.
- Pass mode, i_ready = 0; row 2 pulses 11 then 12 -> o_valid holds (2, 11) and the next hold is full; a third pulse of 13 sets o_overflow and 13 is lost; raise i_ready -> (2, 11) then (2, 12).
- Reduce mode, G = 4, rows 0..3 enabled, values 1000, 2000, -500, 7; pulses arrive on different cycles -> a single output (0, 2507), emitted only after the last member is captured.
- Reduce mode, G = 4, DATA_WIDTH 16, OUT_WIDTH 17; four rows of 32767 -> o_data = 65535 (saturated), o_overflow = 1; i_clear_ovf -> 0.
- i_cfg_load while o_valid = 1 -> o_cfg_err pulses for one cycle and the mode is unchanged; repeat once o_idle = 1 -> config is taken.
- Reduce mode, G = 3, NUM_ROWS = 16, row 15 only enabled in the partial last group 5; row 15 pulses 4 -> (5, 4). Assert reset mid-transfer -> o_valid = 0 and o_idle = 1 immediately.
